// File: rtl/tx_frame_feeder.sv
// Frame feeder for the RS485 UART transmitter: buffers acquisition bytes into
// frame slots, requests transmission per completed frame and serves byte fetches.
module tx_frame_feeder #(
    parameter int BYTES  = 4,
    parameter int CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       rq,
    output logic [5:0] cycle,
    input  logic       full,
    input  logic       rq_rom,
    input  logic [8:0] addr,
    output logic [7:0] data,
    output logic       ack,
    output logic       ovf,
    output logic [6:0] frames
);

    localparam int SW    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int AW    = SW + 2;
    localparam int DEPTH = CYCLES * 4;

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_LOAD, R_ACK} rstate_t;

    tstate_t        t_state_q;
    rstate_t        r_state_q;
    logic           full_m_q, full_s_q, rqrom_m_q, rqrom_s_q;
    logic [SW-1:0]  wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [6:0]     frames_q, frames_d;
    logic           ovf_q, rq_q, ack_q;
    logic [7:0]     data_q, rd_q;
    logic [7:0]     mem [DEPTH];

    logic           wr_fire, frame_done, tx_done;
    logic [AW-1:0]  wr_idx;

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == SW'(CYCLES - 1)) ? '0 : s + 1'b1;
    endfunction

    assign in_ready = (frames_q < 7'(CYCLES));
    assign rq       = rq_q;
    assign ack      = ack_q;
    assign data     = data_q;
    assign ovf      = ovf_q;
    assign frames   = frames_q;
    assign cycle    = 6'(rd_slot_q);
    assign wr_idx   = {wr_slot_q, byte_idx_q};

    always_comb begin
        wr_fire    = in_valid & in_ready;
        frame_done = wr_fire & (byte_idx_q == 2'(BYTES - 1));
        tx_done    = (t_state_q == T_REL) & ~full_s_q;
        byte_idx_d = byte_idx_q;
        wr_slot_d  = wr_slot_q;
        rd_slot_d  = rd_slot_q;
        if (wr_fire) byte_idx_d = frame_done ? 2'd0 : byte_idx_q + 2'd1;
        if (frame_done) wr_slot_d = slot_inc(wr_slot_q);
        if (tx_done) rd_slot_d = slot_inc(rd_slot_q);
        // Completion and release in the same clk cancel out
        frames_d = frames_q + 7'(frame_done) - 7'(tx_done);
    end

    // Two-flop synchronisers for the edgeTx-domain controls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_m_q  <= 1'b0;
            full_s_q  <= 1'b0;
            rqrom_m_q <= 1'b0;
            rqrom_s_q <= 1'b0;
        end else begin
            full_m_q  <= full;
            full_s_q  <= full_m_q;
            rqrom_m_q <= rq_rom;
            rqrom_s_q <= rqrom_m_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            byte_idx_q <= 2'd0;
            frames_q   <= 7'd0;
            ovf_q      <= 1'b0;
        end else begin
            wr_slot_q  <= wr_slot_d;
            rd_slot_q  <= rd_slot_d;
            byte_idx_q <= byte_idx_d;
            frames_q   <= frames_d;
            ovf_q      <= ovf_q | (in_valid & ~in_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_idx] <= in_data;
    end

    // Out-of-range fetch addresses read as zero
    always_ff @(posedge clk) begin
        if (r_state_q == R_READ) rd_q <= (addr < 9'(DEPTH)) ? mem[addr[AW-1:0]] : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_state_q <= T_IDLE;
            rq_q      <= 1'b0;
        end else begin
            case (t_state_q)
                T_IDLE: begin
                    rq_q <= 1'b0;
                    if (frames_q != 7'd0) begin
                        t_state_q <= T_REQ;
                        rq_q      <= 1'b1;
                    end
                end
                T_REQ: begin
                    if (full_s_q) begin
                        t_state_q <= T_REL;
                        rq_q      <= 1'b0;
                    end
                end
                T_REL: begin
                    rq_q <= 1'b0;
                    if (!full_s_q) t_state_q <= T_IDLE;
                end
                default: begin
                    t_state_q <= T_IDLE;
                    rq_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            ack_q     <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    ack_q <= 1'b0;
                    if (rqrom_s_q) r_state_q <= R_READ;
                end
                R_READ: r_state_q <= R_LOAD;
                R_LOAD: begin
                    data_q    <= rd_q;
                    ack_q     <= 1'b1;
                    r_state_q <= R_ACK;
                end
                R_ACK: begin
                    if (!rqrom_s_q) begin
                        ack_q     <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    ack_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_feeder.sv
// Directed self-checking bench for tx_frame_feeder; a small transmitter model
// drives full/rq_rom/addr and each scenario task checks its own expectations.
module tb_tx_frame_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, rq, ack, ovf;
    logic [5:0] cycle;
    logic       full = 1'b0;
    logic       rq_rom = 1'b0;
    logic [8:0] addr = 9'd0;
    logic [7:0] data;
    logic [6:0] frames;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_frame_feeder #(.BYTES(4), .CYCLES(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rq(rq), .cycle(cycle), .full(full),
        .rq_rom(rq_rom), .addr(addr), .data(data), .ack(ack), .ovf(ovf),
        .frames(frames)
    );

    // Stimulus helpers: start and end on a falling edge, report observations only.
    task automatic write_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_rq(output bit seen, output int n);
        n = 0;
        while (rq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        seen = (rq === 1'b1);
    endtask

    task automatic fetch(input logic [8:0] a, output logic [7:0] d, output int up, output int dn);
        addr   = a;
        rq_rom = 1'b1;
        up     = 0;
        do begin
            @(negedge clk);
            up++;
        end while (ack !== 1'b1 && up < 12);
        d      = data;
        rq_rom = 1'b0;
        dn     = 0;
        do begin
            @(negedge clk);
            dn++;
        end while (ack !== 1'b0 && dn < 12);
    endtask

    task automatic release_frame(output int n_low, output int n_done);
        logic [5:0] c0;
        c0    = cycle;
        full  = 1'b1;
        n_low = 0;
        do begin
            @(negedge clk);
            n_low++;
        end while (rq !== 1'b0 && n_low < 12);
        full   = 1'b0;
        n_done = 0;
        do begin
            @(negedge clk);
            n_done++;
        end while (cycle === c0 && n_done < 12);
    endtask

    task automatic test_reset();
        checks++; if (rq !== 1'b0) begin errors++; $display("FAIL reset_rq: got %b want 0", rq); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
        checks++; if (cycle !== 6'd0) begin errors++; $display("FAIL reset_cycle: got %0d want 0", cycle); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (frames !== 7'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_frame();
        bit seen;
        int n;
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
        checks++; if (frames !== 7'd1) begin errors++; $display("FAIL single_frames: got %0d want 1", frames); end
        wait_rq(seen, n);
        checks++; if (!seen || n > 2) begin errors++; $display("FAIL single_rq: seen %0d after %0d clk want within 2", seen, n); end
        checks++; if (cycle !== 6'd0) begin errors++; $display("FAIL single_cycle: got %0d want 0", cycle); end
    endtask

    task automatic test_fetch();
        logic [7:0] d;
        int up, dn;
        fetch(9'd2, d, up, dn);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL fetch_data: got %h want 33", d); end
        checks++; if (up < 4 || up > 5) begin errors++; $display("FAIL fetch_ack_latency: got %0d want 4..5", up); end
        checks++; if (dn < 2 || dn > 3) begin errors++; $display("FAIL fetch_ack_drop: got %0d want 2..3", dn); end
        checks++; if (data !== 8'h33) begin errors++; $display("FAIL fetch_hold: got %h want 33", data); end
        fetch(9'd0, d, up, dn);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL fetch_addr0: got %h want 11", d); end
        fetch(9'd300, d, up, dn);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL fetch_out_of_range: got %h want 00", d); end
    endtask

    task automatic test_release();
        int nl, nd;
        release_frame(nl, nd);
        checks++; if (nl != 3) begin errors++; $display("FAIL release_rq_low: got %0d clk want 3", nl); end
        checks++; if (nd != 3) begin errors++; $display("FAIL release_done: got %0d clk want 3", nd); end
        checks++; if (frames !== 7'd0) begin errors++; $display("FAIL release_frames: got %0d want 0", frames); end
        checks++; if (cycle !== 6'd1) begin errors++; $display("FAIL release_cycle: got %0d want 1", cycle); end
        checks++; if (rq !== 1'b0) begin errors++; $display("FAIL release_rq: got %b want 0", rq); end
    endtask

    // 64 frames land in slots 1..63,0 while the transmitter holds off.
    task automatic test_capacity();
        logic [7:0] d;
        int up, dn, nl, nd;
        bit seen;
        for (int f = 0; f < 64; f++)
            for (int b = 0; b < 4; b++)
                write_byte(8'(f * 4 + b) ^ 8'h5A);
        checks++; if (frames !== 7'd64) begin errors++; $display("FAIL cap_frames: got %0d want 64", frames); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cap_in_ready: got %b want 0", in_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL cap_ovf_early: got %b want 0", ovf); end
        write_byte(8'hEE);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL cap_ovf: got %b want 1", ovf); end
        checks++; if (frames !== 7'd64) begin errors++; $display("FAIL cap_frames_after_drop: got %0d want 64", frames); end
        fetch(9'd4, d, up, dn);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL cap_mem_unchanged: got %h want 5a", d); end
        wait_rq(seen, up);
        checks++; if (!seen || cycle !== 6'd1) begin errors++; $display("FAIL cap_rq_cycle: rq %0d cycle %0d want 1 and 1", seen, cycle); end
        release_frame(nl, nd);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cap_in_ready_after: got %b want 1", in_ready); end
        checks++; if (frames !== 7'd63) begin errors++; $display("FAIL cap_frames_after: got %0d want 63", frames); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL cap_ovf_sticky: got %b want 1", ovf); end
    endtask

    // Drain the remaining 63 frames: cycle runs 2..63 then wraps to 0.
    task automatic test_wrap();
        logic [7:0] d;
        logic [5:0] exp_c;
        int up, dn, nl, nd, n;
        bit seen;
        for (int i = 0; i < 63; i++) begin
            exp_c = 6'((2 + i) % 64);
            wait_rq(seen, n);
            checks++; if (!seen || cycle !== exp_c) begin errors++; $display("FAIL wrap_cycle: rq %0d cycle %0d want %0d", seen, cycle, exp_c); end
            if (exp_c == 6'd0) begin
                for (int b = 0; b < 4; b++) begin
                    fetch(9'(b), d, up, dn);
                    checks++; if (d !== (8'(252 + b) ^ 8'h5A)) begin errors++; $display("FAIL wrap_slot0_byte%0d: got %h want %h", b, d, 8'(252 + b) ^ 8'h5A); end
                end
            end
            release_frame(nl, nd);
            checks++; if (nd >= 12) begin errors++; $display("FAIL wrap_release_timeout: got %0d clk want <12", nd); end
        end
        checks++; if (frames !== 7'd0) begin errors++; $display("FAIL wrap_frames: got %0d want 0", frames); end
        checks++; if (cycle !== 6'd1) begin errors++; $display("FAIL wrap_final_cycle: got %0d want 1", cycle); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        int up, dn, nl, nd, n;
        bit seen;
        write_byte(8'hA0); write_byte(8'hA1); write_byte(8'hA2); write_byte(8'hA3);
        wait_rq(seen, n);
        checks++; if (!seen || cycle !== 6'd1) begin errors++; $display("FAIL sim_rq_a: rq %0d cycle %0d want 1 and 1", seen, cycle); end
        write_byte(8'hB0); write_byte(8'hB1); write_byte(8'hB2);
        full = 1'b1;
        n = 0;
        while (rq !== 1'b0 && n < 12) begin @(negedge clk); n++; end
        full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cycle !== 6'd1 || frames !== 7'd1) begin errors++; $display("FAIL sim_pre: cycle %0d frames %0d want 1 and 1", cycle, frames); end
        // Last byte of B lands on the edge where the release completes
        write_byte(8'hB3);
        checks++; if (frames !== 7'd1) begin errors++; $display("FAIL sim_frames: got %0d want 1", frames); end
        checks++; if (cycle !== 6'd2) begin errors++; $display("FAIL sim_cycle: got %0d want 2", cycle); end
        wait_rq(seen, n);
        checks++; if (!seen || cycle !== 6'd2) begin errors++; $display("FAIL sim_rq_b: rq %0d cycle %0d want 1 and 2", seen, cycle); end
        write_byte(8'hC0);
        fetch(9'd12, d, up, dn);
        checks++; if (d !== 8'hC0) begin errors++; $display("FAIL sim_wr_slot: got %h want c0", d); end
        fetch(9'd11, d, up, dn);
        checks++; if (d !== 8'hB3) begin errors++; $display("FAIL sim_b_last: got %h want b3", d); end
        release_frame(nl, nd);
        checks++; if (frames !== 7'd0 || cycle !== 6'd3) begin errors++; $display("FAIL sim_release_b: frames %0d cycle %0d want 0 and 3", frames, cycle); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int up, dn, nl, nd, n;
        bit seen;
        write_byte(8'hC1); write_byte(8'hC2); write_byte(8'hC3);
        wait_rq(seen, n);
        write_byte(8'h99);
        addr   = 9'd12;
        rq_rom = 1'b1;
        n = 0;
        while (ack !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        checks++; if (ack !== 1'b1 || rq !== 1'b1) begin errors++; $display("FAIL rmid_pre: ack %b rq %b want 1 and 1", ack, rq); end
        checks++; if (data !== 8'hC0) begin errors++; $display("FAIL rmid_data: got %h want c0", data); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rmid_ack: got %b want 0", ack); end
        checks++; if (rq !== 1'b0) begin errors++; $display("FAIL rmid_rq: got %b want 0", rq); end
        checks++; if (frames !== 7'd0) begin errors++; $display("FAIL rmid_frames: got %0d want 0", frames); end
        checks++; if (cycle !== 6'd0) begin errors++; $display("FAIL rmid_cycle: got %0d want 0", cycle); end
        checks++; if (ovf !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ovf_ready: ovf %b in_ready %b want 0 and 1", ovf, in_ready); end
        rq_rom = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        write_byte(8'hF0); write_byte(8'hF1); write_byte(8'hF2); write_byte(8'hF3);
        wait_rq(seen, n);
        checks++; if (!seen || cycle !== 6'd0) begin errors++; $display("FAIL rmid_fresh_rq: rq %0d cycle %0d want 1 and 0", seen, cycle); end
        fetch(9'd0, d, up, dn);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL rmid_fresh_byte0: got %h want f0", d); end
        fetch(9'd3, d, up, dn);
        checks++; if (d !== 8'hF3) begin errors++; $display("FAIL rmid_fresh_byte3: got %h want f3", d); end
        release_frame(nl, nd);
        checks++; if (frames !== 7'd0 || cycle !== 6'd1) begin errors++; $display("FAIL rmid_fresh_release: frames %0d cycle %0d want 0 and 1", frames, cycle); end
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_single_frame();
        test_fetch();
        test_release();
        test_capacity();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
